// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter
//
// Shares one block_ram between an instruction-fetch port (read-only) and a
// data port (read/write with byte strobes). Requests are arbitrated
// round-robin and served one at a time. block_ram has no byte enables, so
// partial-word writes become read-modify-write sequences.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   i_valid/i_ready     fetch request handshake, i_addr = word address
//   i_resp_valid/data   one-cycle fetch response pulse, data held between pulses
//   d_valid/d_ready     data request handshake
//   d_addr, d_write     word address, 1 = write / 0 = read
//   d_wstrb, d_wdata    byte strobes (bit k -> bits [8k+7:8k]) and write data
//   d_resp_valid/data   one-cycle response pulse; data is 0 on write acknowledge
//   ram_write_en/address/data  RAM write port
//   ram_read_address    RAM read address
//   ram_read_data       RAM registered read data (one cycle after address)

module block_ram_arbiter #(
  parameter int SIZE  = 1024,
  parameter int WIDTH = 32,
  localparam int NB   = WIDTH / 8,
  localparam int AW   = $clog2(SIZE / NB)
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             i_valid,
  output logic             i_ready,
  input  logic [AW-1:0]    i_addr,
  output logic             i_resp_valid,
  output logic [WIDTH-1:0] i_resp_data,

  input  logic             d_valid,
  output logic             d_ready,
  input  logic [AW-1:0]    d_addr,
  input  logic             d_write,
  input  logic [NB-1:0]    d_wstrb,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_resp_valid,
  output logic [WIDTH-1:0] d_resp_data,

  output logic             ram_write_en,
  output logic [AW-1:0]    ram_write_address,
  output logic [WIDTH-1:0] ram_write_data,
  output logic [AW-1:0]    ram_read_address,
  input  logic [WIDTH-1:0] ram_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_WAIT,
    RMW_WR
  } state_t;

  state_t state;
  state_t state_next;

  // prio_d = 1 means the data port wins the next tie (i.e. fetch was granted last).
  logic             prio_d;
  logic             grant_d;
  logic             grant_i;
  logic             wr_full;
  logic             wr_empty;

  // Request captured at accept; drives the RAM while the access is in flight.
  logic [AW-1:0]    lat_addr;
  logic [NB-1:0]    lat_wstrb;
  logic [WIDTH-1:0] lat_wdata;
  logic             lat_port_d;

  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] merge_word;

  // Round-robin grant: a lone requester always wins; on a tie the port that
  // was not granted last wins.
  always_comb begin
    grant_d = d_valid && (!i_valid || prio_d);
    grant_i = i_valid && !grant_d;
  end

  always_comb begin
    wr_full  = &d_wstrb;
    wr_empty = ~|d_wstrb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshakes and RAM port drive. Full-word writes go straight to
  // the RAM in the accept cycle; empty writes touch nothing. The RMW_WR write
  // is suppressed under reset so an abandoned merge never lands in the RAM.
  always_comb begin
    state_next        = state;
    i_ready           = 1'b0;
    d_ready           = 1'b0;
    ram_write_en      = 1'b0;
    ram_write_address = d_addr;
    ram_write_data    = d_wdata;
    ram_read_address  = lat_addr;

    case (state)
      IDLE: begin
        i_ready          = grant_i && !reset;
        d_ready          = grant_d && !reset;
        ram_read_address = grant_d ? d_addr : i_addr;
        if (i_ready) begin
          state_next = RD_WAIT;
        end else if (d_ready) begin
          if (!d_write) begin
            state_next = RD_WAIT;
          end else if (wr_full) begin
            ram_write_en = 1'b1;
          end else if (!wr_empty) begin
            state_next = RMW_WAIT;
          end
        end
      end
      RD_WAIT: begin
        state_next = IDLE;
      end
      RMW_WAIT: begin
        state_next = RMW_WR;
      end
      RMW_WR: begin
        ram_write_en      = !reset;
        ram_write_address = lat_addr;
        ram_write_data    = merge_word;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the accepted request and flip the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_d     <= 1'b1;
      lat_addr   <= '0;
      lat_wstrb  <= '0;
      lat_wdata  <= '0;
      lat_port_d <= 1'b0;
    end else if (i_ready) begin
      prio_d     <= 1'b1;
      lat_addr   <= i_addr;
      lat_port_d <= 1'b0;
    end else if (d_ready) begin
      prio_d     <= 1'b0;
      lat_addr   <= d_addr;
      lat_wstrb  <= d_wstrb;
      lat_wdata  <= d_wdata;
      lat_port_d <= 1'b1;
    end
  end

  // Byte merge of the old RAM word with the strobed bytes of the new data.
  always_comb begin
    merged = ram_read_data;
    for (int k = 0; k < NB; k++) begin
      if (lat_wstrb[k]) begin
        merged[8*k +: 8] = lat_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      merge_word <= '0;
    end else if (state == RMW_WAIT) begin
      merge_word <= merged;
    end
  end

  // Response pulses. Read data comes from the RAM in RD_WAIT; writes are
  // acknowledged with zero data one cycle after the RAM write is committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_valid <= 1'b0;
      d_resp_data  <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      if (state == RD_WAIT) begin
        if (lat_port_d) begin
          d_resp_valid <= 1'b1;
          d_resp_data  <= ram_read_data;
        end else begin
          i_resp_valid <= 1'b1;
          i_resp_data  <= ram_read_data;
        end
      end else if ((state == RMW_WR) ||
                   (d_ready && d_write && (wr_full || wr_empty))) begin
        d_resp_valid <= 1'b1;
        d_resp_data  <= '0;
      end
    end
  end

endmodule
